// File: rtl/sha256_compress.sv
// SHA-256 compression engine: 64 rounds fed one W[t] per accepted cycle, result folded into H.
// Optional SHA-224 IV/output mode is compiled in when SHA224_MODE_EN is defined.
module sha256_compress #(
  parameter int DATA_WIDTH = 32,
  parameter int ROUNDS     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic                  first_in,
`ifdef SHA224_MODE_EN
  input  logic                  mode224_in,
`endif
  input  logic                  w_valid_in,
  input  logic [DATA_WIDTH-1:0] w_in,
  output logic [6:0]            round_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [255:0]          digest_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [6:0] LAST = 7'(ROUNDS - 1);

  localparam logic [0:7][31:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  state_t            state_r, state_s;
  logic [6:0]        cnt_r;
  logic              busy_r, done_r;
  logic [0:7][31:0]  hh_r;   // H0..H7, element 0 lands in digest MSBs
  logic [0:7][31:0]  wk_r;   // working a..h
  logic [0:7][31:0]  round_s;
  logic [31:0]       t1_s, t2_s;
`ifdef SHA224_MODE_EN
  localparam logic [0:7][31:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  logic mode224_r;
`endif

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  if (start_in) state_s = S_LOAD; else state_s = S_IDLE;
      S_LOAD:  state_s = S_ROUND;
      S_ROUND: if (w_valid_in && (cnt_r == LAST)) state_s = S_FINAL; else state_s = S_ROUND;
      S_FINAL: state_s = S_DONE;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // One compression round on the current a..h.
  always_comb begin
    t1_s = wk_r[7] + big_s1(wk_r[4]) + ((wk_r[4] & wk_r[5]) ^ (~wk_r[4] & wk_r[6]))
         + K_TAB[cnt_r[5:0]] + w_in;
    t2_s = big_s0(wk_r[0]) + ((wk_r[0] & wk_r[1]) ^ (wk_r[0] & wk_r[2]) ^ (wk_r[1] & wk_r[2]));
    round_s = {t1_s + t2_s, wk_r[0], wk_r[1], wk_r[2], wk_r[3] + t1_s, wk_r[4], wk_r[5], wk_r[6]};
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == S_LOAD) || (state_s == S_ROUND) || (state_s == S_FINAL);
      done_r  <= (state_s == S_DONE);
    end
  end

  // Hash, working variables and round counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh_r  <= IV256;
      wk_r  <= '0;
      cnt_r <= 7'd0;
`ifdef SHA224_MODE_EN
      mode224_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          cnt_r <= 7'd0;
          if (start_in && first_in) begin
`ifdef SHA224_MODE_EN
            mode224_r <= mode224_in;
            hh_r      <= mode224_in ? IV224 : IV256;
`else
            hh_r      <= IV256;
`endif
          end
        end
        S_LOAD: begin
          wk_r  <= hh_r;
          cnt_r <= 7'd0;
        end
        S_ROUND: begin
          if (w_valid_in) begin
            wk_r  <= round_s;
            cnt_r <= (cnt_r == LAST) ? 7'd0 : cnt_r + 7'd1;
          end
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) hh_r[i] <= hh_r[i] + wk_r[i];
        end
        default: cnt_r <= 7'd0;
      endcase
    end
  end

  assign round_out = cnt_r;
  assign busy_out  = busy_r;
  assign done_out  = done_r;
`ifdef SHA224_MODE_EN
  assign digest_out = mode224_r ? {hh_r[0:6], 32'h0} : hh_r;
`else
  assign digest_out = hh_r;
`endif

endmodule

// File: tb/tb_sha256_compress.sv
// Scoreboard bench for sha256_compress: the bench plays the expansion stage, pushes expected
// digest/done-cycle per block, and a negedge monitor pops and compares on every done_out.
module tb_sha256_compress;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_in = 1'b0;
  logic         first_in = 1'b0;
  logic         w_valid_in = 1'b0;
  logic [31:0]  w_in = 32'h0;
  logic [6:0]   round_out;
  logic         busy_out;
  logic         done_out;
  logic [255:0] digest_out;
`ifdef SHA224_MODE_EN
  logic         mode224_in = 1'b0;
`endif

  localparam logic [255:0] IV256 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  typedef struct {
    logic [255:0] dig;
    logic         chk;
    int           cyc;
    string        name;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] msg [16];
  logic [31:0] sched [64];

  sha256_compress #(.DATA_WIDTH(32), .ROUNDS(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_in   (start_in),
    .first_in   (first_in),
`ifdef SHA224_MODE_EN
    .mode224_in (mode224_in),
`endif
    .w_valid_in (w_valid_in),
    .w_in       (w_in),
    .round_out  (round_out),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .digest_out (digest_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message schedule, as the upstream expansion stage would produce it.
  task automatic expand();
    for (int t = 0; t < 16; t++) sched[t] = msg[t];
    for (int t = 16; t < 64; t++)
      sched[t] = (rotr(sched[t-2], 17) ^ rotr(sched[t-2], 19) ^ (sched[t-2] >> 10))
               + sched[t-7]
               + (rotr(sched[t-15], 7) ^ rotr(sched[t-15], 18) ^ (sched[t-15] >> 3))
               + sched[t-16];
  endtask

  task automatic clear_msg();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
  endtask

  // Monitor: every done_out must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done_out=1 at cycle %0d expected no done", cyc);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_done_cycle"}, 256'(cyc), 256'(e.cyc));
        if (e.chk) check({e.name, "_digest"}, digest_out, e.dig);
      end
    end
  end

  // Issue one block; stall inserts 3 idle cycles at t=0,17,63; abort_at>=0 pulls reset at that t.
  task automatic run_block(input logic first, input logic [255:0] dig, input logic chk,
                           input string nm, input logic stall, input int abort_at);
    exp_t e;
    expand();
    @(negedge clk);
    start_in = 1'b1;
    first_in = first;
    e.dig = dig;
    e.chk = chk;
    e.cyc = cyc + 67 + (stall ? 9 : 0);
    e.name = nm;
    if (abort_at < 0) sb_q.push_back(e);
    @(negedge clk);
    start_in = 1'b0;
    first_in = 1'b0;
    w_valid_in = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 64; t++) begin
      if (t == abort_at) begin
        rst_n = 1'b0;
        w_valid_in = 1'b0;
        return;
      end
      if (stall && (t == 0 || t == 17 || t == 63)) begin
        for (int s = 0; s < 3; s++) begin
          w_valid_in = 1'b0;
          check({nm, "_stall_round"}, 256'(round_out), 256'(t));
          @(negedge clk);
        end
      end
      w_valid_in = 1'b1;
      w_in = sched[t];
      if (t == 0 || t == 31 || t == 63) check({nm, "_round_out"}, 256'(round_out), 256'(t));
      @(negedge clk);
    end
    w_valid_in = 1'b0;
    check({nm, "_busy_final"}, 256'(busy_out), 256'(1));
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got no done_out expected done within budget", nm);
      sb_q.delete();
    end
  endtask

  task automatic load_abc();
    clear_msg();
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_digest", digest_out, IV256);
    check("reset_round", 256'(round_out), 256'(0));
    check("reset_busy", 256'(busy_out), 256'(0));
    check("reset_done", 256'(done_out), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    load_abc();
    run_block(1'b1, D_ABC, 1'b1, "abc", 1'b0, -1);
    repeat (3) @(negedge clk);
    check("abc_digest_hold", digest_out, D_ABC);
    check("idle_round", 256'(round_out), 256'(0));
    check("idle_busy", 256'(busy_out), 256'(0));

    clear_msg();
    msg[0] = 32'h80000000;
    run_block(1'b1, D_EMPTY, 1'b1, "empty", 1'b0, -1);

    msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    run_block(1'b1, 256'h0, 1'b0, "two_b1", 1'b0, -1);
    clear_msg();
    msg[15] = 32'h000001c0;
    run_block(1'b0, D_TWO, 1'b1, "two_b2", 1'b0, -1);

    load_abc();
    run_block(1'b1, D_ABC, 1'b1, "abc_stall", 1'b1, -1);

    run_block(1'b1, D_ABC, 1'b0, "abort", 1'b0, 30);
    repeat (2) @(negedge clk);
    check("abort_digest_iv", digest_out, IV256);
    check("abort_busy", 256'(busy_out), 256'(0));
    check("abort_round", 256'(round_out), 256'(0));
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    run_block(1'b1, D_ABC, 1'b1, "abc_after_reset", 1'b0, -1);

`ifdef SHA224_MODE_EN
    mode224_in = 1'b1;
    run_block(1'b1, {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0},
              1'b1, "abc224", 1'b0, -1);
    mode224_in = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
